// File: rtl/alvo_if.sv
// Target bus: projectile geometry in, target position and status out.
// The target side uses the slave modport; the game/renderer side uses master.
interface alvo_if;
  logic [9:0] bolaX;
  logic [9:0] bolaY;
  logic [9:0] bolaRaio;
  logic       bolaAtiva;
  logic [9:0] x;
  logic [9:0] y;
  logic [1:0] vidas;
  logic       visivel;
  logic       acerto;
  logic       destruido;

  modport slave (
    input  bolaX, bolaY, bolaRaio, bolaAtiva,
    output x, y, vidas, visivel, acerto, destruido
  );

  modport master (
    output bolaX, bolaY, bolaRaio, bolaAtiva,
    input  x, y, vidas, visivel, acerto, destruido
  );
endinterface

// File: rtl/alvo.sv
// Patrolling destructible target: moves on divider ticks, detects projectile
// overlap, pulses acerto per hit, blinks while immune, vanishes when dead.
module alvo #(
  parameter int XI          = 320,
  parameter int Y0          = 60,
  parameter int LARGURA     = 40,
  parameter int ALTURA      = 16,
  parameter int VIDAS       = 3,
  parameter int XMIN        = 0,
  parameter int XMAX        = 639,
  parameter int DIV         = 50000,
  parameter int PISCA_TICKS = 200
) (
  input logic CLOCK_50,
  input logic reset,
  input logic pausa,
  input logic reiniciarJogo,
  alvo_if.slave bus
);

  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PWR = $clog2(PISCA_TICKS + 1);
  localparam int PW  = (PWR > 5) ? PWR : 5;

  localparam logic [9:0]    X_INI  = 10'(XI);
  localparam logic [9:0]    X_LO   = 10'(XMIN);
  localparam logic [10:0]   X_HI   = 11'(XMAX);
  localparam logic [10:0]   W_M1   = 11'(LARGURA - 1);
  localparam logic [10:0]   H_M1   = 11'(ALTURA - 1);
  localparam logic [10:0]   Y_TOP  = 11'(Y0);
  localparam logic [1:0]    V_INI  = 2'(VIDAS);
  localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);
  localparam logic [PW-1:0] P_LAST = PW'(PISCA_TICKS - 1);

  typedef enum logic [1:0] {
    ATIVO,
    ATINGIDO,
    DESTRUIDO
  } estado_t;

  estado_t       st, st_n;
  logic [9:0]    xr, x_n;
  logic          dir, dir_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [PW-1:0] pis, pis_n;
  logic [1:0]    vid, vid_n;
  logic          ac, ac_n;

  logic          tick;
  logic          colide;
  logic          hit;
  logic          at_right;
  logic          at_left;

  logic [10:0]   bx, by, br, xw;

  assign bx = {1'b0, bus.bolaX};
  assign by = {1'b0, bus.bolaY};
  assign br = {1'b0, bus.bolaRaio};
  assign xw = {1'b0, xr};

  assign tick = !pausa && (cnt == C_LAST);

  // 11-bit sums: worst case 639+39+1023 stays below 2048
  assign colide = (bx + br >= xw)
               && (bx <= xw + W_M1 + br)
               && (by + br >= Y_TOP)
               && (by <= Y_TOP + H_M1 + br);

  assign hit = (st == ATIVO) && bus.bolaAtiva
            && !pausa && colide;

  assign at_right = (xw + W_M1) >= X_HI;
  assign at_left  = xr <= X_LO;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      st  <= ATIVO;
      xr  <= X_INI;
      dir <= 1'b1;
      cnt <= '0;
      pis <= '0;
      vid <= V_INI;
      ac  <= 1'b0;
    end else begin
      st  <= st_n;
      xr  <= x_n;
      dir <= dir_n;
      cnt <= cnt_n;
      pis <= pis_n;
      vid <= vid_n;
      ac  <= ac_n;
    end
  end

  always_comb begin
    st_n  = st;
    x_n   = xr;
    dir_n = dir;
    cnt_n = cnt;
    pis_n = pis;
    vid_n = vid;
    ac_n  = 1'b0;

    if (!pausa)
      cnt_n = tick ? '0 : cnt + CW'(1);

    if (tick && st != DESTRUIDO) begin
      unique case (1'b1)
        dir && at_right:   dir_n = 1'b0;
        dir && !at_right:  x_n = xr + 10'd1;
        !dir && at_left:   dir_n = 1'b1;
        !dir && !at_left:  x_n = xr - 10'd1;
      endcase
    end

    unique case (st)
      ATIVO: begin
        if (hit) begin
          ac_n  = 1'b1;
          vid_n = vid - 2'd1;
          pis_n = '0;
          st_n  = (vid == 2'd1) ? DESTRUIDO : ATINGIDO;
        end
      end
      ATINGIDO: begin
        if (tick) begin
          if (pis == P_LAST) begin
            pis_n = '0;
            st_n  = ATIVO;
          end else begin
            pis_n = pis + PW'(1);
          end
        end
      end
      DESTRUIDO: begin
        st_n = DESTRUIDO;
      end
      default: begin
        st_n = ATIVO;
      end
    endcase

    if (reiniciarJogo) begin
      st_n  = ATIVO;
      x_n   = X_INI;
      dir_n = 1'b1;
      cnt_n = '0;
      pis_n = '0;
      vid_n = V_INI;
      ac_n  = 1'b0;
    end
  end

  // pis[4] flips every 16 immune ticks and is 0 on entry
  assign bus.x         = xr;
  assign bus.y         = 10'(Y0);
  assign bus.vidas     = vid;
  assign bus.visivel   = (st == ATIVO) || (st == ATINGIDO && pis[4]);
  assign bus.acerto    = ac;
  assign bus.destruido = (st == DESTRUIDO);

endmodule

// File: tb/tb_alvo.sv
// Bench for alvo: directed scenarios plus randomized projectile traffic,
// all compared against a cycle-level behavioural model of the target.
module tb_alvo;

  localparam int DIV   = 4;
  localparam int PISCA = 8;
  localparam int L     = 40;
  localparam int H     = 16;
  localparam int XI    = 320;
  localparam int Y0    = 60;
  localparam int VIDAS = 3;
  localparam int XMIN  = 0;
  localparam int XMAX  = 639;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic pausa = 1'b0;
  logic rein  = 1'b0;

  always #5 clk = ~clk;

  alvo_if bus ();
  alvo_if bus2 ();

  alvo #(
    .XI(XI), .Y0(Y0), .LARGURA(L), .ALTURA(H), .VIDAS(VIDAS),
    .XMIN(XMIN), .XMAX(XMAX), .DIV(DIV), .PISCA_TICKS(PISCA)
  ) dut (
    .CLOCK_50(clk),
    .reset(rst),
    .pausa(pausa),
    .reiniciarJogo(rein),
    .bus(bus.slave)
  );

  alvo #(
    .XI(322), .Y0(Y0), .LARGURA(L), .ALTURA(H), .VIDAS(VIDAS),
    .XMIN(XMIN), .XMAX(363), .DIV(DIV), .PISCA_TICKS(PISCA)
  ) dut2 (
    .CLOCK_50(clk),
    .reset(rst),
    .pausa(1'b0),
    .reiniciarJogo(1'b0),
    .bus(bus2.slave)
  );

  int tests = 0;
  int fails = 0;

  // model: mode 0 = normal, 1 = immune, 2 = dead
  int m_x, m_right, m_vidas, m_cnt, m_mode, m_el, m_ac;

  function automatic void m_reset();
    m_x = XI; m_right = 1; m_vidas = VIDAS;
    m_cnt = 0; m_mode = 0; m_el = 0; m_ac = 0;
  endfunction

  function automatic bit overlap(int bx, int by, int br, int xx);
    return (bx + br >= xx) && (bx <= xx + L - 1 + br)
        && (by + br >= Y0) && (by <= Y0 + H - 1 + br);
  endfunction

  function automatic void m_clock();
    bit tk, hit;
    if (rein) begin
      m_reset();
      return;
    end
    if (pausa) begin
      m_ac = 0;
      return;
    end
    tk = (m_cnt == DIV - 1);
    m_cnt = (m_cnt + 1) % DIV;
    hit = (m_mode == 0) && bus.bolaAtiva &&
          overlap(int'(bus.bolaX), int'(bus.bolaY), int'(bus.bolaRaio), m_x);
    m_ac = hit ? 1 : 0;
    if (tk && m_mode != 2) begin
      if (m_right == 1) begin
        if (m_x + L - 1 >= XMAX) m_right = 0;
        else m_x = m_x + 1;
      end else begin
        if (m_x <= XMIN) m_right = 1;
        else m_x = m_x - 1;
      end
    end
    if (m_mode == 1 && tk) begin
      m_el++;
      if (m_el >= PISCA) begin
        m_mode = 0;
        m_el = 0;
      end
    end
    if (hit) begin
      m_vidas--;
      m_mode = (m_vidas == 0) ? 2 : 1;
      m_el = 0;
    end
  endfunction

  function automatic int m_vis();
    if (m_mode == 0) return 1;
    if (m_mode == 2) return 0;
    return (m_el / 16) % 2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    tests++;
    assert (obs === 32'(exp)) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("x", {22'd0, bus.x}, m_x);
    chk("y", {22'd0, bus.y}, Y0);
    chk("vidas", {30'd0, bus.vidas}, m_vidas);
    chk("visivel", {31'd0, bus.visivel}, m_vis());
    chk("acerto", {31'd0, bus.acerto}, m_ac);
    chk("destruido", {31'd0, bus.destruido}, (m_mode == 2) ? 1 : 0);
  endtask

  task automatic step();
    m_clock();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    int pulses, invis, xfz, tmp;

    bus.bolaX = '0; bus.bolaY = '0; bus.bolaRaio = '0; bus.bolaAtiva = 1'b0;
    bus2.bolaX = '0; bus2.bolaY = '0; bus2.bolaRaio = '0; bus2.bolaAtiva = 1'b0;
    m_reset();
    #12;
    check_all();
    rst = 1'b0;

    // idle patrol, plus bounce on the narrow instance
    pulses = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (bus.acerto) pulses++;
      if (i == 4)  chk("bounce_t1", {22'd0, bus2.x}, 323);
      if (i == 8)  chk("bounce_t2", {22'd0, bus2.x}, 324);
      if (i == 12) chk("bounce_hold", {22'd0, bus2.x}, 324);
      if (i == 16) chk("bounce_back", {22'd0, bus2.x}, 323);
    end
    chk("patrol_x", {22'd0, bus.x}, 330);
    chk("patrol_vidas", {30'd0, bus.vidas}, 3);
    chk("patrol_no_hit", 32'(pulses), 0);
    chk("bounce_t10", {22'd0, bus2.x}, 317);

    // first hit with a fixed ball
    bus.bolaX = 10'd340; bus.bolaY = 10'd70;
    bus.bolaRaio = 10'd5; bus.bolaAtiva = 1'b1;
    pulses = 0;
    invis = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.acerto) pulses++;
      if (!bus.visivel && !bus.destruido) invis++;
    end
    chk("one_pulse", 32'(pulses), 1);
    chk("vidas_after_hit", {30'd0, bus.vidas}, 2);

    // chase the target with the ball until destroyed
    for (int i = 0; i < 400 && m_mode != 2; i++) begin
      bus.bolaX = 10'(m_x + 20);
      step();
      if (bus.acerto) pulses++;
      if (!bus.visivel && !bus.destruido) invis++;
    end
    chk("three_pulses", 32'(pulses), 3);
    chk("blink_low", 32'((invis >= 58 && invis <= 64) ? 1 : 0), 1);
    chk("dead_vidas", {30'd0, bus.vidas}, 0);
    chk("dead_flag", {31'd0, bus.destruido}, 1);
    chk("dead_invis", {31'd0, bus.visivel}, 0);

    xfz = m_x;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      bus.bolaX = 10'(xfz + 20);
      step();
      if (bus.acerto) pulses++;
    end
    chk("dead_no_hit", 32'(pulses), 0);
    chk("dead_frozen", {22'd0, bus.x}, xfz);

    // synchronous restart from DESTRUIDO
    rein = 1'b1;
    step();
    rein = 1'b0;
    chk("rein_x", {22'd0, bus.x}, 320);
    chk("rein_vidas", {30'd0, bus.vidas}, 3);
    chk("rein_vis", {31'd0, bus.visivel}, 1);
    chk("rein_dead", {31'd0, bus.destruido}, 0);

    // pause with overlapping ball
    pausa = 1'b1;
    bus.bolaX = 10'd340; bus.bolaY = 10'd70;
    bus.bolaRaio = 10'd5; bus.bolaAtiva = 1'b1;
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (bus.acerto) pulses++;
    end
    chk("pause_no_hit", 32'(pulses), 0);
    chk("pause_x", {22'd0, bus.x}, 320);
    chk("pause_vidas", {30'd0, bus.vidas}, 3);
    pausa = 1'b0;
    step();
    chk("resume_hit", {31'd0, bus.acerto}, 1);

    // async reset while immune and mid-pulse
    #2;
    rst = 1'b1;
    m_reset();
    #1;
    check_all();
    chk("rst_acerto", {31'd0, bus.acerto}, 0);
    chk("rst_x", {22'd0, bus.x}, 320);
    chk("rst_vis", {31'd0, bus.visivel}, 1);
    #1;
    rst = 1'b0;

    // randomized traffic around the target
    for (int i = 0; i < 800; i++) begin
      pausa = ($urandom_range(0, 7) == 0);
      rein  = ($urandom_range(0, 63) == 0);
      bus.bolaAtiva = 1'($urandom_range(0, 1));
      tmp = m_x + int'($urandom_range(0, 80)) - 20;
      if (tmp < 0) tmp = 0;
      bus.bolaX = 10'(tmp);
      bus.bolaY = 10'($urandom_range(30, 100));
      bus.bolaRaio = 10'($urandom_range(0, 15));
      step();
    end
    pausa = 1'b0;
    rein = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
